// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-cell modulo counter.
//   DIR_UP / DIR_DN : encodings of the up_dn direction input.
//   clamp_mod       : min(value, modulus-1), used to bound parallel loads.
package tff_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int unsigned clamp_mod(input int unsigned value,
                                            input int unsigned modulus);
    return (value >= modulus) ? (modulus - 1) : value;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit toggle flip-flop.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (q -> 0)
//   t     : toggle enable, q inverts on the edge when high
//   q     : registered bit
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n)  r_q <= 1'b0;
    else if (t)  r_q <= ~r_q;
  end

  assign q = r_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH toggle cells.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : count one step per clock while high
//   up_dn      : 1 = up, 0 = down
//   load       : parallel load strobe (beats en), value clamped to MODULUS-1
//   load_val   : value to load
//   q          : current count (registered, always < MODULUS)
//   tc         : terminal count for the current direction (combinational)
//   wrap       : registered one-cycle pulse on a modulo wrap
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_wrap_nxt;
  logic             r_wrap;

  assign w_load_clamped = WIDTH'(clamp_mod(32'(load_val), MODULUS));

  always_comb begin
    w_next     = w_q;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_next = w_load_clamped;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (w_q == MAXV) begin
          w_next     = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_next = w_q + WIDTH'(1);
        end
      end else begin
        if (w_q == '0) begin
          w_next     = MAXV;
          w_wrap_nxt = 1'b1;
        end else begin
          w_next = w_q - WIDTH'(1);
        end
      end
    end
  end

  // Every state change, including loads, is expressed as a set of bit toggles.
  assign w_t = w_q ^ w_next;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (w_t[gi]),
      .q     (w_q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_wrap <= 1'b0;
    else        r_wrap <= w_wrap_nxt;
  end

  assign q    = w_q;
  assign tc   = (up_dn == DIR_UP) ? (w_q == MAXV) : (w_q == '0);
  assign wrap = r_wrap;

endmodule

// File: tb/tb_tff_mod_counter.sv
module tb_tff_mod_counter;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_q;
    logic       exp_wrap;
    logic       exp_tc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap;

  // Second instance at the smallest legal modulus.
  logic       en2, up2, load2;
  logic [0:0] lv2;
  logic [0:0] q2;
  logic       tc2, wrap2;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
  );

  tff_mod_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .up_dn(up2), .load(load2),
    .load_val(lv2), .q(q2), .tc(tc2), .wrap(wrap2)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] lv, input logic [3:0] eq,
                     input logic ew, input logic et);
    vec_t v;
    v.rst_n = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv;
    v.exp_q = eq; v.exp_wrap = ew; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  task automatic step2(input logic e, input logic u, input logic l, input logic lv,
                       input int eq, input int ew, input int et, input string nm);
    @(negedge clk);
    en2 = e; up2 = u; load2 = l; lv2 = lv;
    @(posedge clk); #1;
    chk({nm, ".q"}, int'(q2), eq);
    chk({nm, ".wrap"}, int'(wrap2), ew);
    chk({nm, ".tc"}, int'(tc2), et);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; lv2 = '0;

    // rst  en up ld lv   q  wr tc
    add(0, 1, 1, 1, 7,   0, 0, 0);   // reset beats load/en
    add(0, 1, 1, 1, 7,   0, 0, 0);
    for (int i = 1; i <= 9; i++)
      add(1, 1, 1, 0, 0, 4'(i), 0, (i == 9));
    add(1, 1, 1, 0, 0,   0, 1, 0);   // up wrap 9 -> 0
    add(1, 0, 0, 1, 2,   2, 0, 0);   // load 2, down
    add(1, 1, 0, 0, 0,   1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 0, 1);
    add(1, 1, 0, 0, 0,   9, 1, 0);   // down wrap 0 -> 9
    add(1, 1, 0, 0, 0,   8, 0, 0);
    add(1, 1, 1, 1, 15,  9, 0, 1);   // clamped load, en ignored
    add(1, 0, 1, 1, 3,   3, 0, 0);
    add(1, 0, 1, 1, 5,   5, 0, 0);
    add(1, 1, 1, 0, 0,   6, 0, 0);
    add(1, 1, 1, 0, 0,   7, 0, 0);
    add(1, 1, 0, 0, 0,   6, 0, 0);   // direction flip
    add(1, 0, 0, 0, 0,   6, 0, 0);   // hold
    add(1, 0, 0, 0, 0,   6, 0, 0);
    add(1, 0, 0, 0, 0,   6, 0, 0);
    add(1, 0, 1, 1, 7,   7, 0, 0);
    add(1, 1, 1, 0, 0,   8, 0, 0);
    add(0, 1, 1, 0, 0,   0, 0, 0);   // reset mid-count
    add(1, 1, 1, 0, 0,   1, 0, 0);   // resume from 0

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; en = vecs[i].en; up_dn = vecs[i].up_dn;
      load = vecs[i].load; load_val = vecs[i].load_val;
      @(posedge clk); #1;
      chk($sformatf("v%0d.q", i), int'(q), int'(vecs[i].exp_q));
      chk($sformatf("v%0d.wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
      chk($sformatf("v%0d.tc", i), int'(tc), int'(vecs[i].exp_tc));
    end

    // tc follows up_dn combinationally with no clock edge.
    @(negedge clk);
    en = 1'b0; load = 1'b1; load_val = 4'd0; up_dn = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("tc0.up", int'(tc), 0);
    up_dn = 1'b0; #1;
    chk("tc0.dn", int'(tc), 1);
    load = 1'b1; load_val = 4'd9; up_dn = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("tc9.up", int'(tc), 1);
    up_dn = 1'b0; #1;
    chk("tc9.dn", int'(tc), 0);

    // MODULUS=2 corner: alternating wraps in both directions.
    step2(0, 1, 1, 0, 0, 0, 0, "m2.load0");
    step2(1, 1, 0, 0, 1, 0, 1, "m2.up1");
    step2(1, 1, 0, 0, 0, 1, 0, "m2.up2");
    step2(1, 1, 0, 0, 1, 0, 1, "m2.up3");
    step2(1, 0, 0, 0, 0, 0, 1, "m2.dn1");
    step2(1, 0, 0, 0, 1, 1, 0, "m2.dn2");
    step2(0, 0, 0, 0, 1, 0, 0, "m2.hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
